// File: rtl/mantissa_align_add_2.sv
// Two-stage mantissa alignment and signed-magnitude add.
// Stage 1 right-shifts both significands onto the common exponent. Each shifted
// significand carries two extra low bits, guard and sticky, and every bit shifted
// out is folded into the sticky bit.
// Stage 2 adds or subtracts the aligned magnitudes according to the operand signs.
// Both stages use valid/ready handshakes. in_ready is combinational, so a full
// pipeline can accept an input on the same cycle that it emits a result.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake
//   input_sign         operand signs, bit i = operand i (1 = negative)
//   input_sig          significands including hidden bit, slice i = operand i
//   max_exp            common exponent, passed through to out_exp
//   exp_offset_num     per-operand right-shift amount, slice i = operand i
//   out_valid/out_ready output handshake
//   sum_sign           result sign (0 for a zero result)
//   sum_mag            {carry, significand, guard, sticky}
//   out_exp            max_exp captured with the same input transfer
module mantissa_align_add_2 #(
  parameter int unsigned expWidth = 3,
  parameter int unsigned sigWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              input_sign,
  input  logic [2*sigWidth-1:0]   input_sig,
  input  logic [expWidth-1:0]     max_exp,
  input  logic [2*expWidth-1:0]   exp_offset_num,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sum_sign,
  output logic [sigWidth+2:0]     sum_mag,
  output logic [expWidth-1:0]     out_exp
);

  localparam int unsigned ExtW = sigWidth + 2;
  localparam int unsigned SumW = sigWidth + 3;

  // Append the guard and sticky positions, then shift right.
  // Bits shifted out are ORed into bit 0.
  // Shifting by ExtW or more leaves only the sticky bit, which is set
  // when the significand is non-zero.
  function automatic logic [ExtW-1:0] align(input logic [sigWidth-1:0] sig,
                                            input logic [expWidth-1:0] off);
    logic [ExtW-1:0] ext;
    logic [ExtW-1:0] mask;
    logic [ExtW-1:0] res;
    ext  = {sig, 2'b00};
    mask = ~({ExtW{1'b1}} << off);
    if (32'(off) >= ExtW) begin
      res = {{(ExtW-1){1'b0}}, |ext};
    end else begin
      res = (ext >> off) | {{(ExtW-1){1'b0}}, |(ext & mask)};
    end
    return res;
  endfunction

  logic                s1_valid;
  logic [ExtW-1:0]     s1_a0;
  logic [ExtW-1:0]     s1_a1;
  logic [1:0]          s1_sign;
  logic [expWidth-1:0] s1_exp;

  logic            s2_adv;
  logic [ExtW-1:0] a0_in;
  logic [ExtW-1:0] a1_in;
  logic [SumW-1:0] a0x;
  logic [SumW-1:0] a1x;
  logic [SumW-1:0] sum_d;
  logic            sign_d;

  assign s2_adv   = !out_valid || out_ready;
  // Hold off new inputs while reset is asserted.
  assign in_ready = rst_n && (!s1_valid || s2_adv);

  always_comb begin
    a0_in = align(input_sig[0 +: sigWidth], exp_offset_num[0 +: expWidth]);
    a1_in = align(input_sig[sigWidth +: sigWidth], exp_offset_num[expWidth +: expWidth]);
  end

  always_comb begin
    a0x    = {1'b0, s1_a0};
    a1x    = {1'b0, s1_a1};
    sum_d  = '0;
    sign_d = 1'b0;
    if (s1_sign[0] == s1_sign[1]) begin
      sum_d  = a0x + a1x;
      sign_d = s1_sign[0];
    end else if (a0x >= a1x) begin
      sum_d  = a0x - a1x;
      sign_d = s1_sign[0];
    end else begin
      sum_d  = a1x - a0x;
      sign_d = s1_sign[1];
    end
    // Exact cancellation, or two zero operands, always gives +0.
    if (sum_d == '0) begin
      sign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a0    <= '0;
      s1_a1    <= '0;
      s1_sign  <= '0;
      s1_exp   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a0   <= a0_in;
        s1_a1   <= a1_in;
        s1_sign <= input_sign;
        s1_exp  <= max_exp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum_sign  <= 1'b0;
      sum_mag   <= '0;
      out_exp   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      // Load data only with a valid result, so the outputs hold steady.
      if (s1_valid) begin
        sum_sign <= sign_d;
        sum_mag  <= sum_d;
        out_exp  <= s1_exp;
      end
    end
  end

endmodule

// File: tb/tb_mantissa_align_add_2.sv
module tb_mantissa_align_add_2;

  localparam int SW = 5;
  localparam int EW = 3;
  localparam int MW = SW + 3;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      input_sign;
  logic [2*SW-1:0] input_sig;
  logic [EW-1:0]   max_exp;
  logic [2*EW-1:0] exp_offset_num;
  logic            out_valid;
  logic            out_ready;
  logic            sum_sign;
  logic [MW-1:0]   sum_mag;
  logic [EW-1:0]   out_exp;

  mantissa_align_add_2 #(.expWidth(EW), .sigWidth(SW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .input_sign     (input_sign),
    .input_sig      (input_sig),
    .max_exp        (max_exp),
    .exp_offset_num (exp_offset_num),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .sum_sign       (sum_sign),
    .sum_mag        (sum_mag),
    .out_exp        (out_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          s;
    logic [MW-1:0] m;
    logic [EW-1:0] e;
  } res_t;

  res_t q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   accepted = 0;

  // Reference: integer division for the shift, remainder for sticky,
  // signed integer sum for sign and magnitude.
  function automatic int align_ref(int sig, int off);
    int ext;
    int p;
    ext = sig * 4;
    if (off >= SW + 2) return (sig != 0) ? 1 : 0;
    p = 1 << off;
    return (ext / p) | (((ext % p) != 0) ? 1 : 0);
  endfunction

  function automatic res_t model(logic [1:0] sg, logic [2*SW-1:0] sigs,
                                 logic [2*EW-1:0] offs, logic [EW-1:0] e);
    int   a0;
    int   a1;
    int   v;
    res_t r;
    a0  = align_ref(int'(sigs[SW-1:0]), int'(offs[EW-1:0]));
    a1  = align_ref(int'(sigs[2*SW-1:SW]), int'(offs[2*EW-1:EW]));
    v   = (sg[0] ? -a0 : a0) + (sg[1] ? -a1 : a1);
    r.s = (v < 0);
    r.m = MW'((v < 0) ? -v : v);
    r.e = e;
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, score, then advance past posedge.
  task automatic tick();
    res_t r;
    @(negedge clk);
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        r = q[0];
        check("sb_sign", 32'(sum_sign), 32'(r.s));
        check("sb_mag", 32'(sum_mag), 32'(r.m));
        check("sb_exp", 32'(out_exp), 32'(r.e));
        if (out_ready) void'(q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(input_sign, input_sig, exp_offset_num, max_exp));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [1:0] sg, int s0, int s1, int o0, int o1, int e);
    input_sign     = sg;
    input_sig      = {SW'(s1), SW'(s0)};
    exp_offset_num = {EW'(o1), EW'(o0)};
    max_exp        = EW'(e);
  endtask

  task automatic directed(string tag, logic [1:0] sg, int s0, int s1, int o0, int o1,
                          int e, int xm, int xs);
    drive(sg, s0, s1, o0, o1, e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mag"}, 32'(sum_mag), 32'(xm));
    check({tag, "_sign"}, 32'(sum_sign), 32'(xs));
    check({tag, "_exp"}, 32'(out_exp), 32'(e));
    tick();
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int acc0;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    input_sign     = '0;
    input_sig      = '0;
    max_exp        = '0;
    exp_offset_num = '0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum_mag", 32'(sum_mag), 32'd0);
    check("rst_sum_sign", 32'(sum_sign), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    directed("basic", 2'b00, 16, 24, 0, 2, 5, 88, 0);
    directed("sticky", 2'b00, 16, 31, 0, 7, 3, 65, 0);
    directed("cancel", 2'b10, 16, 16, 0, 0, 2, 0, 0);
    directed("diff_pos", 2'b01, 16, 16, 1, 0, 4, 32, 0);
    directed("diff_neg", 2'b10, 16, 16, 1, 0, 6, 32, 1);
    directed("neg_same", 2'b11, 31, 31, 0, 0, 7, 248, 1);

    // Backpressure: two items fit, and the third stalls until release.
    out_ready = 1'b0;
    acc0      = accepted;
    drive(2'b00, 17, 3, 1, 2, 1);
    in_valid = 1'b1;
    tick();
    drive(2'b01, 20, 9, 0, 3, 2);
    tick();
    drive(2'b10, 7, 30, 4, 0, 3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("bp_accepted", 32'(accepted - acc0), 32'd2);
    check("bp_held_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    drain("bp_drain");

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(2'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)));
      tick();
    end
    drain("rand_drain");

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(2'b00, 31, 31, 0, 0, 7);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum_mag", 32'(sum_mag), 32'd0);
    check("mid_rst_sum_sign", 32'(sum_sign), 32'd0);
    check("mid_rst_out_exp", 32'(out_exp), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    check("no_stale", 32'(out_valid), 32'd0);

    directed("after_rst", 2'b00, 16, 24, 0, 2, 5, 88, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mantissa_align_add_2.md
MANTISSA_ALIGN_ADD_2 -- requirements
Module: mantissa_align_add_2

Interface
REQ-001 Parameter: expWidth, default 3, exponent field width; matches the upstream exponent normalizer.
REQ-002 Parameter: sigWidth, default 5, significand width including hidden bit.
REQ-003 Port: clk  input  1  rising-edge clock; single clock domain.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  input operand pair valid.
REQ-006 Port: in_ready  output  1  block accepts an input this cycle.
REQ-007 Port: input_sign  input  2  operand signs; bit i = operand i, 1 = negative.
REQ-008 Port: input_sig  input  2*sigWidth  significands; slice i = operand i.
REQ-009 Port: max_exp  input  expWidth  common exponent from the normalizer.
REQ-010 Port: exp_offset_num  input  2*expWidth  per-operand right-shift amount; slice i = operand i.
REQ-011 Port: out_valid  output  1  result valid.
REQ-012 Port: out_ready  input  1  downstream accepts the result.
REQ-013 Port: sum_sign  output  1  result sign.
REQ-014 Port: sum_mag  output  sigWidth+3  result magnitude: carry, sigWidth significand bits, guard, sticky.
REQ-015 Port: out_exp  output  expWidth  max_exp carried alongside the result.

Function
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 The pipeline has two register stages: S1 holds the aligned operands; S2 holds the result. Unstalled latency is 2 cycles from input transfer to out_valid; throughput is 1 per cycle.
REQ-018 S2 advances when !out_valid || out_ready; S1 advances into S2 when S1 is valid and S2 advances; in_ready = !s1_valid || S2 advances (combinational, no extra bubble).
REQ-019 Alignment per operand: ext = {sig, 2'b00} (sigWidth+2 bits); aligned = ext >> offset; bit 0 of aligned is ORed with the OR of all bits shifted out (sticky).
REQ-020 An offset >= sigWidth+2 yields aligned = 1 if sig != 0, else 0.
REQ-021 Equal signs: sum_mag = a0 + a1, sum_sign = the common sign.
REQ-022 Different signs: sum_mag = |a0 - a1|; sum_sign = sign of the larger-magnitude operand.
REQ-023 A zero result always has sum_sign = 0, including the case of equal magnitudes with opposite signs.
REQ-024 out_exp equals the max_exp captured with the same transfer; no normalization or rounding is done in this block.
REQ-025 While out_valid && !out_ready, sum_sign, sum_mag and out_exp hold stable.
REQ-026 When both stages are full and out_ready = 0, in_ready = 0; no data is dropped or duplicated.
REQ-027 Simultaneous input and output transfer on a full pipeline shifts all stages by one and accepts the new input.

Reset
REQ-028 Reset asserted: s1_valid = 0, out_valid = 0, sum_sign = 0, sum_mag = 0, out_exp = 0, immediately (asynchronous).
REQ-029 While rst_n = 0, in_ready = 0; after release it = 1 on the first clock edge.
REQ-030 Reset mid-operation discards all in-flight data; no out_valid occurs for inputs accepted before reset.

Verification
REQ-031 Signs 00, sig0 = 16, sig1 = 24, offsets (0,2), max_exp = 5 -> after 2 cycles: sum_mag = 88, sum_sign = 0, out_exp = 5.
REQ-032 Signs 00, sig0 = 16 offset 0, sig1 = 31 offset 7 -> sum_mag = 65 (sticky only from operand 1), sum_sign = 0.
REQ-033 Signs 01 (op1 negative), sig0 = sig1 = 16, offsets (0,0) -> sum_mag = 0, sum_sign = 0.
REQ-034 Signs 10 (op1 positive, op0 negative), sig0 = 16 offset 1, sig1 = 16 offset 0 -> sum_mag = 32, sum_sign = 0; with signs swapped (op1 negative) -> sum_mag = 32, sum_sign = 1.
REQ-035 Hold out_ready = 0 and drive 3 back-to-back valid inputs -> 2 accepted, in_ready = 0 on the 3rd. Release out_ready -> results emerge in order with no loss.
REQ-036 Assert rst_n = 0 with both stages full -> out_valid = 0 and outputs = 0 immediately. Release -> no stale result is ever emitted.
